// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader: framed UART byte stream into the 2048x16 instruction memory
module imem_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic        we,
  output logic [10:0] waddr,
  output logic [15:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [11:0] MAX_WORDS = 12'd2048;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SYNC   = 4'd1;
  localparam logic [3:0] S_CNT_HI = 4'd2;
  localparam logic [3:0] S_CNT_LO = 4'd3;
  localparam logic [3:0] S_DAT_HI = 4'd4;
  localparam logic [3:0] S_DAT_LO = 4'd5;
  localparam logic [3:0] S_CHK    = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  logic [3:0]  state;
  logic [3:0]  count_hi;
  logic [11:0] count;
  logic [11:0] idx;
  logic [7:0]  hold;
  logic [7:0]  csum;
  logic [11:0] cnt_next;

  // Every presented byte is taken in the cycle it appears, whatever the state.
  assign clr_rx_rdy = rst_n & rx_rdy;
  assign cnt_next   = {count_hi, rx_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count_hi <= 4'd0;
      count    <= 12'd0;
      idx      <= 12'd0;
      hold     <= 8'd0;
      csum     <= 8'd0;
      we       <= 1'b0;
      waddr    <= 11'd0;
      wdata    <= 16'd0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we <= 1'b0;
      if (start) begin
        state    <= S_SYNC;
        idx      <= 12'd0;
        csum     <= 8'd0;
        waddr    <= 11'd0;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
      end else if (rx_rdy) begin
        case (state)
          S_SYNC: begin
            if (rx_data == SYNC_BYTE) state <= S_CNT_HI;
          end
          S_CNT_HI: begin
            count_hi <= rx_data[3:0];
            csum     <= csum ^ rx_data;
            state    <= S_CNT_LO;
          end
          S_CNT_LO: begin
            count <= cnt_next;
            csum  <= csum ^ rx_data;
            // Range check up front guarantees waddr can never wrap.
            if (cnt_next == 12'd0 || cnt_next > MAX_WORDS) begin
              state    <= S_ERR;
              err      <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_DAT_HI;
            end
          end
          S_DAT_HI: begin
            hold  <= rx_data;
            csum  <= csum ^ rx_data;
            state <= S_DAT_LO;
          end
          S_DAT_LO: begin
            csum  <= csum ^ rx_data;
            we    <= 1'b1;
            wdata <= {hold, rx_data};
            waddr <= idx[10:0];
            idx   <= idx + 12'd1;
            state <= (idx + 12'd1 == count) ? S_CHK : S_DAT_HI;
          end
          S_CHK: begin
            cpu_hold <= 1'b0;
            if (rx_data == csum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized frames against a word-list reference model for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic        we;
  logic [10:0] waddr;
  logic [15:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .clr_rx_rdy(clr_rx_rdy), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int dbl_we = 0;
  logic prev_we = 1'b0;
  logic exp_done, exp_err;
  logic [7:0]  frame_q[$];
  logic [26:0] exp_q[$];
  logic [26:0] obs_q[$];
  logic [7:0]  nom [10] = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h2D};

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we) obs_q.push_back({waddr, wdata});
    if (we && prev_we) dbl_we++;
    prev_we = we;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_after_start", cpu_hold, 1);
    chk("done_cleared", done, 0);
    chk("err_cleared", err, 0);
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    chk("ack", clr_rx_rdy, 1);
    tick();
    rx_rdy = 1'b0;
    repeat ($urandom_range(0, maxgap)) tick();
  endtask

  task automatic send_frame(input int maxgap);
    foreach (frame_q[i]) send(frame_q[i], maxgap);
    frame_q.delete();
  endtask

  // Reference: a frame is sync, count, count words, XOR of everything after sync.
  task automatic build(input logic [7:0] chi, input logic [7:0] clo, input bit bad_chk);
    int cnt;
    logic [15:0] w;
    logic [7:0] x;
    cnt = {chi[3:0], clo};
    frame_q.push_back(8'hA5);
    frame_q.push_back(chi);
    frame_q.push_back(clo);
    x = chi ^ clo;
    if (cnt < 1 || cnt > 2048) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      w = 16'($urandom);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[7:0]);
      x = x ^ w[15:8] ^ w[7:0];
      exp_q.push_back({11'(i), w});
    end
    frame_q.push_back(bad_chk ? ~x : x);
    exp_done = !bad_chk;
    exp_err  = bad_chk;
  endtask

  task automatic push_nominal(input logic [7:0] ck);
    for (int i = 0; i < 9; i++) frame_q.push_back(nom[i]);
    frame_q.push_back(ck);
    exp_q.push_back({11'd0, 16'h1234});
    exp_q.push_back({11'd1, 16'h5678});
    exp_q.push_back({11'd2, 16'h9ABC});
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_write"}, obs_q[i], exp_q[i]);
    chk({tag, "_we_width"}, dbl_we, 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic finish_check(input string tag);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_hold"}, cpu_hold, 0);
    compare_writes(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_rdy = 1'b1; rx_data = 8'hA5;
    tick(); tick();
    chk("rst_ack", clr_rx_rdy, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1; rx_rdy = 1'b0;
    tick();

    pulse_start(); push_nominal(8'h2D); exp_done = 1; exp_err = 0;
    send_frame(0); finish_check("nominal");

    pulse_start(); push_nominal(8'h2E); exp_done = 0; exp_err = 1;
    send_frame(0); finish_check("bad_chk");

    pulse_start(); build(8'h00, 8'h00, 0); send_frame(0); finish_check("count0");
    pulse_start(); build(8'h08, 8'h01, 0); send_frame(0); finish_check("count2049");

    pulse_start();
    frame_q.push_back(8'hFF); frame_q.push_back(8'h00); frame_q.push_back(8'hA4);
    push_nominal(8'h2D); exp_done = 1; exp_err = 0;
    send_frame(1); finish_check("garbage");

    pulse_start();
    send(8'hA5, 0); send(8'h00, 0); send(8'h02, 0); send(8'h11, 0); send(8'h22, 0);
    exp_q.push_back({11'd0, 16'h1122});
    pulse_start(); push_nominal(8'h2D); exp_done = 1; exp_err = 0;
    send_frame(0); finish_check("restart");

    start = 1'b1; rx_rdy = 1'b1; rx_data = 8'hA5;
    #1; chk("start_ack", clr_rx_rdy, 1);
    tick(); start = 1'b0; rx_rdy = 1'b0;
    push_nominal(8'h2D); exp_done = 1; exp_err = 0;
    send_frame(0); finish_check("start_wins");

    pulse_start(); build(8'h00, 8'h05, 0);
    for (int i = 0; i < 7; i++) send(frame_q[i], 0);
    frame_q.delete();
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    rst_n = 1'b0;
    tick();
    chk("mid_rst_we", we, 0);
    chk("mid_rst_waddr", waddr, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    compare_writes("mid_rst");
    rst_n = 1'b1;
    tick();
    pulse_start(); build(8'h00, 8'h04, 0); send_frame(1); finish_check("after_rst");

    pulse_start(); build(8'hF0, 8'h02, 0); send_frame(0); finish_check("nibble");

    for (int r = 0; r < 6; r++) begin
      int n;
      logic [7:0] hi;
      n = $urandom_range(1, 20);
      hi = {4'($urandom), 4'(n >> 8)};
      pulse_start();
      build(hi, 8'(n), ($urandom_range(0, 2) == 0));
      send_frame(2);
      finish_check("random");
    end

    pulse_start(); build(8'h08, 8'h00, 0); send_frame(0);
    chk("max_last_waddr", waddr, 2047);
    finish_check("max");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
